// File: rtl/johnson_pkg.sv
// Shared definitions for Johnson-counter producers and consumers:
// lock-state encoding, phase count, successor and decode helpers.
package johnson_pkg;

    localparam int unsigned JPHASES = 8;
    localparam int unsigned JCODE_W = 4;
    localparam int unsigned JIDX_W  = 3;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic              legal;
        logic [JIDX_W-1:0] idx;
    } jdecode_t;

    // Next code in the legal 8-state Johnson sequence.
    function automatic logic [JCODE_W-1:0] johnson_next(input logic [JCODE_W-1:0] code);
        return {code[2:0], ~code[3]};
    endfunction

    // Map a code to its phase index; legal=0 for the 8 unreachable codes.
    function automatic jdecode_t johnson_decode(input logic [JCODE_W-1:0] code);
        jdecode_t d;
        d.legal = 1'b1;
        d.idx   = '0;
        case (code)
            4'b0000: d.idx = 3'd0;
            4'b0001: d.idx = 3'd1;
            4'b0011: d.idx = 3'd2;
            4'b0111: d.idx = 3'd3;
            4'b1111: d.idx = 3'd4;
            4'b1110: d.idx = 3'd5;
            4'b1100: d.idx = 3'd6;
            4'b1000: d.idx = 3'd7;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_if.sv
// Bundles the phase decoder's sample inputs and decoded outputs.
//   master: drives en/q_in/err_clr, observes decoded phase and status.
//   slave : the decoder itself.
interface johnson_phase_decoder_if
    import johnson_pkg::*;
#(
    parameter int unsigned ERR_CNT_W = 8
);
    logic                 en;
    logic [JCODE_W-1:0]   q_in;
    logic                 err_clr;
    logic [JPHASES-1:0]   phase_onehot;
    logic [JIDX_W-1:0]    phase_idx;
    logic                 valid;
    logic                 locked;
    logic                 illegal_code;
    logic                 seq_err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en, q_in, err_clr,
        input  phase_onehot, phase_idx, valid, locked, illegal_code, seq_err, err_count
    );

    modport slave (
        input  en, q_in, err_clr,
        output phase_onehot, phase_idx, valid, locked, illegal_code, seq_err, err_count
    );
endinterface

// File: rtl/johnson_lock_fsm.sv
// Lock tracker for the decoded Johnson stream.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   legal_stb    a legal code was decoded this cycle
//   illegal_stb  an illegal code was decoded this cycle
//   succ/rpt/jump transition class of the legal code vs. previous legal code
//   state        current lock state
//   locked       registered (state == LOCKED)
//   seq_err      registered pulse on a JUMP while LOCKED
module johnson_lock_fsm
    import johnson_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        legal_stb,
    input  logic        illegal_stb,
    input  logic        succ,
    input  logic        rpt,
    input  logic        jump,
    output lock_state_t state,
    output logic        locked,
    output logic        seq_err
);

    localparam int unsigned RUN_W = $clog2(LOCK_COUNT + 1);

    lock_state_t      state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [RUN_W:0]   run_inc_c;
    logic             seq_err_d;

    // Next-state logic; run counts consecutive successors while LOCKING.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        seq_err_d = 1'b0;
        run_inc_c = {1'b0, run_q} + (RUN_W + 1)'(1);
        case (state_q)
            UNLOCKED: begin
                if (legal_stb) begin
                    state_d = LOCKING;
                    run_d   = '0;
                end
            end
            LOCKING: begin
                if (illegal_stb) begin
                    state_d = UNLOCKED;
                    run_d   = '0;
                end else if (succ) begin
                    if (run_inc_c == (RUN_W + 1)'(LOCK_COUNT)) begin
                        state_d = LOCKED;
                        run_d   = '0;
                    end else begin
                        run_d = run_inc_c[RUN_W-1:0];
                    end
                end else if (rpt) begin
                    run_d = run_q;
                end else if (jump) begin
                    run_d = '0;
                end
            end
            LOCKED: begin
                if (illegal_stb) begin
                    state_d = UNLOCKED;
                end else if (jump) begin
                    seq_err_d = 1'b1;
                    state_d   = LOCKING;
                    run_d     = '0;
                end
            end
            default: begin
                state_d = UNLOCKED;
                run_d   = '0;
            end
        endcase
    end

    // State register with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
            run_q   <= '0;
            locked  <= 1'b0;
            seq_err <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            locked  <= (state_d == LOCKED);
            seq_err <= seq_err_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/johnson_phase_decoder.sv
// Registers a Johnson counter's output, decodes it to a one-hot phase and
// a phase index, validates codes/transitions, and tracks lock and errors.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   bus (slave) en, q_in, err_clr in; phase_onehot, phase_idx, valid,
//               locked, illegal_code, seq_err, err_count out
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter int unsigned LOCK_COUNT = 3,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    johnson_phase_decoder_if.slave  bus
);

    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    logic [JCODE_W-1:0]   q_s;
    logic                 s_vld;
    logic [JCODE_W-1:0]   prev_q;
    logic [JPHASES-1:0]   onehot_q;
    logic [JIDX_W-1:0]    idx_q;
    logic                 valid_q;
    logic                 illegal_q;
    logic [ERR_CNT_W-1:0] err_q;

    jdecode_t             dec_c;
    logic                 legal_stb_c;
    logic                 illegal_stb_c;
    logic                 succ_c;
    logic                 rpt_c;
    logic                 jump_c;
    logic                 err_evt_c;

    lock_state_t          fsm_state;
    logic                 fsm_locked;
    logic                 fsm_seq_err;

    // Stage 1: capture the counter code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_s   <= '0;
            s_vld <= 1'b0;
        end else begin
            s_vld <= bus.en;
            if (bus.en) begin
                q_s <= bus.q_in;
            end
        end
    end

    // Decode and classify against the last legal code.
    always_comb begin
        dec_c         = johnson_decode(q_s);
        legal_stb_c   = s_vld & dec_c.legal;
        illegal_stb_c = s_vld & ~dec_c.legal;
        succ_c        = legal_stb_c & (q_s == johnson_next(prev_q));
        rpt_c         = legal_stb_c & (q_s == prev_q);
        jump_c        = legal_stb_c & ~succ_c & ~rpt_c;
        // Same condition the FSM uses to raise seq_err.
        err_evt_c     = illegal_stb_c | (jump_c & (fsm_state == LOCKED));
    end

    // Stage 2: registered phase outputs, previous-code memory, error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= '0;
            onehot_q  <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            illegal_q <= 1'b0;
            err_q     <= '0;
        end else begin
            valid_q   <= legal_stb_c;
            illegal_q <= illegal_stb_c;
            if (legal_stb_c) begin
                prev_q   <= q_s;
                idx_q    <= dec_c.idx;
                onehot_q <= JPHASES'(1) << dec_c.idx;
            end else if (illegal_stb_c) begin
                onehot_q <= '0;
            end
            if (bus.err_clr) begin
                err_q <= '0;
            end else if (err_evt_c && (err_q != ERR_MAX)) begin
                err_q <= err_q + ERR_CNT_W'(1);
            end
        end
    end

    johnson_lock_fsm #(
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .legal_stb   (legal_stb_c),
        .illegal_stb (illegal_stb_c),
        .succ        (succ_c),
        .rpt         (rpt_c),
        .jump        (jump_c),
        .state       (fsm_state),
        .locked      (fsm_locked),
        .seq_err     (fsm_seq_err)
    );

    assign bus.phase_onehot = onehot_q;
    assign bus.phase_idx    = idx_q;
    assign bus.valid        = valid_q;
    assign bus.locked       = fsm_locked;
    assign bus.illegal_code = illegal_q;
    assign bus.seq_err      = fsm_seq_err;
    assign bus.err_count    = err_q;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Bench for johnson_phase_decoder: directed test-plan steps followed by a
// random stream, all checked against a phase-index based reference model.
// A second instance with a 2-bit error counter exercises saturation.
module tb_johnson_phase_decoder;

    localparam int LC = 3;

    logic clk;
    logic rst_n;

    johnson_phase_decoder_if #(.ERR_CNT_W(8)) bus1 ();
    johnson_phase_decoder_if #(.ERR_CNT_W(2)) bus2 ();

    johnson_phase_decoder #(.LOCK_COUNT(LC), .ERR_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    johnson_phase_decoder #(.LOCK_COUNT(LC), .ERR_CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] legal_codes [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    int errors = 0;
    int checks = 0;

    // Reference model state: phases handled as indices 0..7.
    bit         m_s_vld;
    logic [3:0] m_q_s;
    int         m_prev;
    int         m_mode;      // 0 unlocked, 1 locking, 2 locked
    int         m_run;
    int         m_err;
    int         m_err2;
    logic [7:0] e_onehot;
    int         e_idx;
    bit         e_valid;
    bit         e_ill;
    bit         e_seq;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("phase_onehot", 32'(bus1.phase_onehot), 32'(e_onehot));
        chk("phase_idx",    32'(bus1.phase_idx),    32'(e_idx));
        chk("valid",        32'(bus1.valid),        32'(e_valid));
        chk("locked",       32'(bus1.locked),       32'(m_mode == 2));
        chk("illegal_code", 32'(bus1.illegal_code), 32'(e_ill));
        chk("seq_err",      32'(bus1.seq_err),      32'(e_seq));
        chk("err_count",    32'(bus1.err_count),    32'(m_err));
        chk("err_count_w2", 32'(bus2.err_count),    32'(m_err2));
        chk("locked_w2",    32'(bus2.locked),       32'(m_mode == 2));
    endtask

    task automatic model_reset();
        m_s_vld = 0; m_q_s = '0; m_prev = 0; m_mode = 0; m_run = 0;
        m_err = 0; m_err2 = 0;
        e_onehot = '0; e_idx = 0; e_valid = 0; e_ill = 0; e_seq = 0;
    endtask

    // One clock of the decode stage, computed from phase indices.
    task automatic model_edge(input bit clr);
        int  idx;
        bit  evt;
        bit  succ;
        bit  rep;
        e_ill = 0; e_seq = 0; evt = 0; e_valid = 0;
        if (m_s_vld) begin
            idx = -1;
            for (int i = 0; i < 8; i++) if (legal_codes[i] == m_q_s) idx = i;
            if (idx < 0) begin
                e_onehot = '0; e_ill = 1; evt = 1; m_mode = 0; m_run = 0;
            end else begin
                succ = (idx == (m_prev + 1) % 8);
                rep  = (idx == m_prev);
                e_valid = 1; e_idx = idx; e_onehot = 8'(1 << idx);
                if (m_mode == 0) begin
                    m_mode = 1; m_run = 0;
                end else if (m_mode == 1) begin
                    if (succ) begin
                        m_run++;
                        if (m_run == LC) begin m_mode = 2; m_run = 0; end
                    end else if (!rep) begin
                        m_run = 0;
                    end
                end else if (!succ && !rep) begin
                    e_seq = 1; evt = 1; m_mode = 1; m_run = 0;
                end
                m_prev = idx;
            end
        end
        if (clr) begin
            m_err = 0; m_err2 = 0;
        end else if (evt) begin
            if (m_err < 255) m_err++;
            if (m_err2 < 3) m_err2++;
        end
    endtask

    task automatic step(input bit e, input logic [3:0] q, input bit clr);
        bus1.en = e; bus1.q_in = q; bus1.err_clr = clr;
        bus2.en = e; bus2.q_in = q; bus2.err_clr = clr;
        model_edge(clr);
        m_s_vld = e;
        if (e) m_q_s = q;
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [3:0] last;
    logic [3:0] q;
    int         li;

    initial begin
        rst_n = 1'b0;
        bus1.en = 0; bus1.q_in = '0; bus1.err_clr = 0;
        bus2.en = 0; bus2.q_in = '0; bus2.err_clr = 0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Lock-in from reset; locked rises with the 4th decode.
        step(1, 4'h0, 0); step(1, 4'h1, 0); step(1, 4'h3, 0);
        step(1, 4'h7, 0);
        step(1, 4'hF, 0);
        chk("lock_after_4", 32'(bus1.locked), 32'd1);
        chk("idx_after_4",  32'(bus1.phase_idx), 32'd3);
        step(1, 4'hE, 0); step(1, 4'hC, 0); step(1, 4'h8, 0);
        step(1, 4'h0, 0);
        chk("onehot_wrap_pre", 32'(bus1.phase_onehot), 32'h80);
        step(1, 4'h0, 0); step(1, 4'h0, 0);   // repeats
        step(1, 4'h1, 0);
        chk("repeat_locked", 32'(bus1.locked), 32'd1);

        // Illegal code while locked, then relock.
        step(1, 4'h5, 0);
        step(1, 4'h3, 0);
        chk("illegal_pulse", 32'(bus1.illegal_code), 32'd1);
        chk("illegal_err",   32'(bus1.err_count), 32'd1);
        step(1, 4'h7, 0); step(1, 4'hF, 0); step(1, 4'hE, 0);
        step(1, 4'hC, 0); step(1, 4'h8, 0); step(1, 4'h0, 0);
        step(1, 4'h1, 0); step(1, 4'h3, 0);

        // Jump while locked at 0011, then relock.
        step(1, 4'hC, 0);
        step(1, 4'h8, 0);
        chk("jump_seq_err", 32'(bus1.seq_err), 32'd1);
        chk("jump_unlock",  32'(bus1.locked), 32'd0);
        step(1, 4'h0, 0); step(1, 4'h1, 0); step(1, 4'h3, 0);
        chk("jump_relock", 32'(bus1.locked), 32'd1);

        // Two more illegal codes: 2-bit counter saturates at 3.
        step(1, 4'hA, 0); step(1, 4'h9, 0); step(1, 4'h0, 0);
        chk("sat_w2", 32'(bus2.err_count), 32'd3);
        step(1, 4'h6, 0);
        step(1, 4'h0, 1);                      // clear coincides with error
        chk("clr_prio", 32'(bus1.err_count), 32'd0);
        step(1, 4'h1, 0); step(1, 4'h3, 0); step(1, 4'h7, 0); step(1, 4'hF, 0);

        // Enable gap while locked.
        step(0, 4'h5, 0); step(0, 4'h2, 0); step(0, 4'h9, 0);
        step(1, 4'hE, 0); step(1, 4'hC, 0);
        chk("gap_locked", 32'(bus1.locked), 32'd1);

        // Asynchronous reset between edges.
        step(1, 4'h8, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #2 rst_n = 1'b1;
        step(1, 4'h3, 0);
        step(1, 4'h7, 0);
        chk("post_rst_valid",  32'(bus1.valid), 32'd1);
        chk("post_rst_locked", 32'(bus1.locked), 32'd0);

        // Random stream: mostly successors, some repeats, junk and gaps.
        last = 4'h7;
        for (int n = 0; n < 300; n++) begin
            li = -1;
            for (int i = 0; i < 8; i++) if (legal_codes[i] == last) li = i;
            if ($urandom_range(0, 15) == 0)      q = 4'($urandom_range(0, 15));
            else if ($urandom_range(0, 9) == 0)  q = last;
            else if (li < 0)                     q = legal_codes[0];
            else                                 q = legal_codes[(li + 1) % 8];
            if ($urandom_range(0, 7) != 0) begin
                step(1, q, $urandom_range(0, 31) == 0);
                last = q;
            end else begin
                step(0, q, $urandom_range(0, 31) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 4-bit synchronous Johnson counter.
- Registers the counter's q, decodes it to an 8-phase one-hot and a 3-bit phase index, and checks every code and every transition against the legal Johnson sequence.
- Maintains a lock FSM and a saturating error counter so phase-sequenced logic and debug can trust the phase outputs only while locked.

Parameters:
- LOCK_COUNT, 3: consecutive legal successor transitions required to go LOCKING -> LOCKED (1..15).
- ERR_CNT_W, 8: width of err_count.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample enable; q_in is sampled when en=1.
- q_in  input  4  Johnson code from the counter.
- err_clr  input  1  synchronous clear of err_count.
- phase_onehot  output  8  one-hot phase; bit i set for phase i.
- phase_idx  output  3  phase number 0..7.
- valid  output  1  phase outputs reflect a legal code decoded this cycle.
- locked  output  1  FSM in LOCKED.
- illegal_code  output  1  one-cycle pulse: decoded code is not one of the 8 legal codes.
- seq_err  output  1  one-cycle pulse: legal code, but a bad transition while LOCKED.
- err_count  output  ERR_CNT_W  saturating error count.

Behaviour:
- Legal sequence, phases 0..7: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000. Successor = {prev[2:0], ~prev[3]}.
- Pipeline has two registered stages:
  - Stage 1: on the edge where en=1, capture q_in into q_s and set s_vld; s_vld=0 otherwise.
  - Stage 2: decode q_s and update all outputs.
  - Latency: q_in sampled at edge k appears on outputs after edge k+1.
- Decode when s_vld=1:
  - Legal code: valid=1, phase_idx=index, phase_onehot=1<<index.
  - Illegal code: valid=0, phase_onehot=0, phase_idx holds, illegal_code=1.
- When s_vld=0: valid=0, phase outputs hold, no FSM action, no pulses.
- Transition classes vs prev (last legal code), evaluated only if the code is legal: SUCC (code == successor), REPEAT (code == prev, a stall), JUMP (any other legal code).
- FSM states: UNLOCKED, LOCKING, LOCKED. run counter width is ceil(log2(LOCK_COUNT+1)).
  - UNLOCKED: legal -> LOCKING, run=0. Illegal -> stay.
  - LOCKING: SUCC -> run+1; when run+1 == LOCK_COUNT -> LOCKED. REPEAT -> stay, run unchanged. JUMP -> stay, run=0. Illegal -> UNLOCKED.
  - LOCKED: SUCC or REPEAT -> stay. JUMP -> seq_err=1, go to LOCKING with run=0. Illegal -> illegal_code=1, go to UNLOCKED.
- prev updates to the decoded code on every legal decode; it is unchanged on illegal decodes.
- locked is registered and equals (state == LOCKED), visible in the same cycle as the decode that caused the transition.
- err_count:
  - +1 on each illegal_code or seq_err pulse; both pulses are never asserted together.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr has priority: count=0 even if an error occurs in the same cycle.
- Reset (async, immediate, mid-operation included):
  - q_s=0, s_vld=0, prev=0000, state=UNLOCKED, run=0.
  - All outputs 0: phase_onehot=0, phase_idx=0, valid=0, locked=0, illegal_code=0, seq_err=0, err_count=0.
  - In-flight samples are discarded. The first decode after reset release is treated as entering from UNLOCKED.

Decomposition:
- Shared package johnson_pkg:
  - Lock-state enum {UNLOCKED, LOCKING, LOCKED}.
  - Constant JPHASES=8.
  - Function johnson_next(code).
  - Function johnson_decode(code) returning {legal, idx[2:0]}.
  - The existing Johnson counter's bench may reuse these.
- One natural sub-module: johnson_lock_fsm.
  - Inputs: legal/SUCC/REPEAT/JUMP strobes.
  - Outputs: state, locked, seq_err.
  - Contains the run counter.
- Top level holds stage-1 capture, decode, prev, and err_count.

Test Plan:
- Reset then en=1 with 0000,0001,0011,0111 on consecutive edges:
  - phase_idx 0,1,2,3 each 2 edges after sampling.
  - locked rises with the 4th decode.
  - err_count=0.
- Locked, stream continues 1111,1110,1100,1000,0000 with wrap:
  - phase_onehot 0x10,0x20,0x40,0x80,0x01, locked stays 1.
  - Insert 0000 twice (REPEAT): no error, locked stays 1.
- Locked, inject 0101 -> illegal_code pulse, valid=0, phase_onehot=0, locked=0, err_count=1. Resume legal stream -> relocks after LOCK_COUNT successors.
- Locked at 0011, inject 1100 (JUMP) -> seq_err pulse, err_count+1, locked=0. Following 1000,0000,0001 -> locked=1 again.
- Force ERR_CNT_W=2 and four errors -> err_count saturates at 3. err_clr asserted together with an error -> err_count=0.
- Assert rst_n=0 mid-stream between edges -> all outputs 0 immediately. Release, first legal decode -> valid=1, locked=0.
- en=0 for 3 cycles while locked -> valid=0, phase holds, no errors. Resume with successor -> locked stays 1.
